// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: RV32I opcodes,
// FSM state encoding and the bundled stall/flush control word.
package hazard_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_ERR      = 2'b10
  } state_t;

  // One bit per pipeline control output, kept together so the output mux
  // selects a whole action at once.
  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_stall;
    logic dec_kill;
  } ctrl_t;

  // No action.
  localparam ctrl_t CTRL_NONE   = '{default: 1'b0};
  // Whole pipe frozen behind a pending data access.
  localparam ctrl_t CTRL_FREEZE = '{pc_stall: 1'b1, if_id_stall: 1'b1, if_id_flush: 1'b0,
                                    id_ex_flush: 1'b0, ex_mem_stall: 1'b1, dec_kill: 1'b0};
  // Taken branch/jump: squash IF/ID and ID/EX contents.
  localparam ctrl_t CTRL_FLUSH  = '{pc_stall: 1'b0, if_id_stall: 1'b0, if_id_flush: 1'b1,
                                    id_ex_flush: 1'b1, ex_mem_stall: 1'b0, dec_kill: 1'b1};
  // Load-use: hold front end, insert one bubble into EX.
  localparam ctrl_t CTRL_BUBBLE = '{pc_stall: 1'b1, if_id_stall: 1'b1, if_id_flush: 1'b0,
                                    id_ex_flush: 1'b1, ex_mem_stall: 1'b0, dec_kill: 1'b1};

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller. The pipeline (master)
// supplies stage information; the controller (slave) returns stall/flush controls.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [6:0]       id_opcode;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             ex_load;
  logic [4:0]       ex_rd;
  logic             ex_redirect;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_stall;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_stall;
  logic             dec_kill;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_opcode, id_rs1, id_rs2, ex_load, ex_rd, ex_redirect, mem_req, mem_ready,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_mem_stall, dec_kill,
           mem_err, stall_cycles
  );

  modport slave (
    input  id_opcode, id_rs1, id_rs2, ex_load, ex_rd, ex_redirect, mem_req, mem_ready,
    output pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_mem_stall, dec_kill,
           mem_err, stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl_src_use_decode.sv
// Decodes which register sources the ID-stage instruction actually reads, so
// that immediate fields aliasing rs1/rs2 never raise a false load-use hazard.
module src_use_decode
  import hazard_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       use_rs1,
  output logic       use_rs2
);

  // Opcode class to source-usage lookup; LUI/AUIPC/JAL and unknown read nothing.
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      OP_R, OP_STORE, OP_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_I, OP_LOAD, OP_JALR: use_rs1 = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32I core: load-use bubbles,
// redirect flushes, MEM-stage freeze with timeout, and a stall-cycle counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  localparam int WAIT_W = $clog2(MAX_WAIT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;
  logic [CNT_W-1:0] stall_cnt;
  logic             mem_err;
  logic             use_rs1;
  logic             use_rs2;
  logic             load_use;
  ctrl_t            ctrl;

  src_use_decode u_src_use_decode (
    .opcode  (bus.id_opcode),
    .use_rs1 (use_rs1),
    .use_rs2 (use_rs2)
  );

  assign load_use = bus.ex_load && (bus.ex_rd != 5'd0) &&
                    ((use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                     (use_rs2 && (bus.id_rs2 == bus.ex_rd)));

  // Next-state and Mealy control outputs; priority is freeze > flush > bubble.
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    ctrl      = CTRL_NONE;
    case (state)
      ST_RUN: begin
        if (bus.mem_req && !bus.mem_ready) begin
          ctrl      = CTRL_FREEZE;
          wait_nxt  = WAIT_W'(1);
          state_nxt = ST_MEM_WAIT;
        end else if (bus.ex_redirect) begin
          // A redirect squashes the hazard instruction too, so no bubble is needed.
          ctrl = CTRL_FLUSH;
        end else if (load_use) begin
          ctrl = CTRL_BUBBLE;
        end
      end
      ST_MEM_WAIT: begin
        // Redirect and load-use are re-evaluated once the freeze releases.
        ctrl = CTRL_FREEZE;
        if (bus.mem_ready) begin
          state_nxt = ST_RUN;
          wait_nxt  = '0;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = ST_ERR;
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      ST_ERR: ctrl = CTRL_FREEZE;
      default: state_nxt = ST_RUN;
    endcase
    if (rst) begin
      ctrl = CTRL_NONE;
    end
  end

  // FSM state and wait-cycle counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Sticky timeout flag and saturating count of PC-stall cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (state_nxt == ST_ERR) begin
        mem_err <= 1'b1;
      end
      if (ctrl.pc_stall && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.pc_stall     = ctrl.pc_stall;
  assign bus.if_id_stall  = ctrl.if_id_stall;
  assign bus.if_id_flush  = ctrl.if_id_flush;
  assign bus.id_ex_flush  = ctrl.id_ex_flush;
  assign bus.ex_mem_stall = ctrl.ex_mem_stall;
  assign bus.dec_kill     = ctrl.dec_kill;
  assign bus.mem_err      = mem_err;
  assign bus.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a per-cycle vector table drives the pipeline inputs,
// expected controls are queued on drive and compared at the following negedge.
module tb_hazard_ctrl;

  localparam int CNT_W = 3;
  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011,
                         ST = 7'b0100011, BR = 7'b1100011, JAL = 7'b1101111,
                         JALR = 7'b1100111, LUI = 7'b0110111, AUI = 7'b0010111,
                         UNK = 7'b1111111;
  // {pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_mem_stall, dec_kill}
  localparam logic [5:0] NONE = 6'b000000, STL = 6'b110101,
                         FLS = 6'b001101, FRZ = 6'b110010;

  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       ld;
    logic [4:0] rd;
    logic       redir;
    logic       req;
    logic       rdy;
    logic [5:0] ctl;
    logic       err;
  } vec_t;

  typedef struct {
    int             idx;
    logic [5:0]     ctl;
    logic           err;
    logic [CNT_W-1:0] cnt;
    logic           cnt_chk;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  exp_t sbq[$];
  vec_t tbl[48];

  hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  hazard_ctrl #(.MAX_WAIT(4), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(logic r, logic [6:0] op, logic [4:0] rs1, logic [4:0] rs2,
                              logic ld, logic [4:0] rd, logic redir, logic req, logic rdy,
                              logic [5:0] ctl, logic err);
    vec_t v;
    v.rst = r; v.op = op; v.rs1 = rs1; v.rs2 = rs2; v.ld = ld; v.rd = rd;
    v.redir = redir; v.req = req; v.rdy = rdy; v.ctl = ctl; v.err = err;
    return v;
  endfunction

  // Scoreboard checker: pops the record queued this cycle and compares.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      logic [5:0] act;
      e   = sbq.pop_front();
      act = {bus.pc_stall, bus.if_id_stall, bus.if_id_flush, bus.id_ex_flush,
             bus.ex_mem_stall, bus.dec_kill};
      n_cmp++;
      if (act !== e.ctl) begin
        n_bad++;
        $display("FAIL ctl[%0d]: got %b expected %b", e.idx, act, e.ctl);
      end
      n_cmp++;
      if (bus.mem_err !== e.err) begin
        n_bad++;
        $display("FAIL mem_err[%0d]: got %b expected %b", e.idx, bus.mem_err, e.err);
      end
      if (e.cnt_chk) begin
        n_cmp++;
        if (bus.stall_cycles !== e.cnt) begin
          n_bad++;
          $display("FAIL stall_cycles[%0d]: got %0d expected %0d", e.idx, bus.stall_cycles, e.cnt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CNT_W-1:0] mcnt;
    logic             known;
    exp_t             e;
    n_cmp = 0; n_bad = 0; mcnt = '0; known = 1'b0;
    rst = 1'b1;
    bus.id_opcode = '0; bus.id_rs1 = '0; bus.id_rs2 = '0; bus.ex_load = 1'b0;
    bus.ex_rd = '0; bus.ex_redirect = 1'b0; bus.mem_req = 1'b0; bus.mem_ready = 1'b0;

    //             rst op   rs1 rs2 ld rd redir req rdy  ctl   err
    tbl[0]  = mk(1, R,   0,  0,  0, 0,  0,  0,  0,  NONE, 0);
    tbl[1]  = mk(1, R,   0,  0,  0, 0,  0,  0,  0,  NONE, 0);
    // load-use on rs2, then released
    tbl[2]  = mk(0, R,   1,  5,  1, 5,  0,  0,  0,  STL,  0);
    tbl[3]  = mk(0, R,   1,  5,  0, 5,  0,  0,  0,  NONE, 0);
    // source-usage decode
    tbl[4]  = mk(0, R,   0,  0,  1, 0,  0,  0,  0,  NONE, 0);
    tbl[5]  = mk(0, LUI, 5,  5,  1, 5,  0,  0,  0,  NONE, 0);
    tbl[6]  = mk(0, JAL, 5,  5,  1, 5,  0,  0,  0,  NONE, 0);
    tbl[7]  = mk(0, I,   5,  9,  1, 5,  0,  0,  0,  STL,  0);
    tbl[8]  = mk(0, I,   3,  5,  1, 5,  0,  0,  0,  NONE, 0);
    tbl[9]  = mk(0, ST,  2,  5,  1, 5,  0,  0,  0,  STL,  0);
    tbl[10] = mk(0, BR,  5,  2,  1, 5,  0,  0,  0,  STL,  0);
    tbl[11] = mk(0, JALR,1,  5,  1, 5,  0,  0,  0,  NONE, 0);
    tbl[12] = mk(0, LD,  5,  0,  1, 5,  0,  0,  0,  STL,  0);
    tbl[13] = mk(0, AUI, 5,  5,  1, 5,  0,  0,  0,  NONE, 0);
    tbl[14] = mk(0, UNK, 5,  5,  1, 5,  0,  0,  0,  NONE, 0);
    // redirect wins over load-use; redirect alone
    tbl[15] = mk(0, R,   5,  0,  1, 5,  1,  0,  0,  FLS,  0);
    tbl[16] = mk(0, R,   5,  0,  0, 5,  1,  0,  0,  FLS,  0);
    // outputs held low during reset even with active requests
    tbl[17] = mk(1, R,   5,  0,  1, 5,  1,  1,  0,  NONE, 0);
    // MEM freeze 4 cycles, redirect/load-use ignored, re-evaluated after
    tbl[18] = mk(0, R,   5,  0,  1, 5,  1,  1,  0,  FRZ,  0);
    tbl[19] = mk(0, R,   5,  0,  1, 5,  1,  1,  0,  FRZ,  0);
    tbl[20] = mk(0, R,   5,  0,  1, 5,  0,  1,  0,  FRZ,  0);
    tbl[21] = mk(0, R,   5,  0,  1, 5,  0,  1,  1,  FRZ,  0);
    tbl[22] = mk(0, R,   5,  0,  1, 5,  0,  0,  0,  STL,  0);
    tbl[23] = mk(0, R,   0,  0,  0, 0,  0,  0,  0,  NONE, 0);
    tbl[24] = mk(0, R,   0,  0,  0, 0,  1,  1,  1,  FLS,  0);
    // counter saturation at 7
    tbl[25] = mk(0, R,   7,  0,  1, 7,  0,  0,  0,  STL,  0);
    tbl[26] = mk(0, R,   7,  0,  1, 7,  0,  0,  0,  STL,  0);
    tbl[27] = mk(0, R,   7,  0,  1, 7,  0,  0,  0,  STL,  0);
    tbl[28] = mk(0, R,   7,  0,  1, 7,  0,  0,  0,  STL,  0);
    tbl[29] = mk(0, R,   0,  0,  0, 0,  0,  0,  0,  NONE, 0);
    // timeout with MAX_WAIT=4, sticky error, reset clears it
    tbl[30] = mk(1, R,   0,  0,  0, 0,  0,  0,  0,  NONE, 0);
    tbl[31] = mk(0, R,   0,  0,  0, 0,  0,  1,  0,  FRZ,  0);
    tbl[32] = mk(0, R,   0,  0,  0, 0,  0,  1,  0,  FRZ,  0);
    tbl[33] = mk(0, R,   0,  0,  0, 0,  0,  1,  0,  FRZ,  0);
    tbl[34] = mk(0, R,   0,  0,  0, 0,  0,  1,  0,  FRZ,  0);
    tbl[35] = mk(0, R,   0,  0,  0, 0,  0,  0,  1,  FRZ,  1);
    tbl[36] = mk(0, R,   5,  0,  1, 5,  1,  0,  0,  FRZ,  1);
    tbl[37] = mk(1, R,   0,  0,  0, 0,  0,  0,  0,  NONE, 1);
    tbl[38] = mk(0, R,   0,  0,  0, 0,  0,  0,  0,  NONE, 0);
    // reset in the middle of a wait, then a full wait that completes in time
    tbl[39] = mk(0, R,   0,  0,  0, 0,  0,  1,  0,  FRZ,  0);
    tbl[40] = mk(0, R,   0,  0,  0, 0,  0,  1,  0,  FRZ,  0);
    tbl[41] = mk(1, R,   0,  0,  0, 0,  0,  1,  0,  NONE, 0);
    tbl[42] = mk(0, R,   0,  0,  0, 0,  0,  0,  0,  NONE, 0);
    tbl[43] = mk(0, R,   0,  0,  0, 0,  0,  1,  0,  FRZ,  0);
    tbl[44] = mk(0, R,   0,  0,  0, 0,  0,  1,  0,  FRZ,  0);
    tbl[45] = mk(0, R,   0,  0,  0, 0,  0,  1,  0,  FRZ,  0);
    tbl[46] = mk(0, R,   0,  0,  0, 0,  0,  1,  1,  FRZ,  0);
    tbl[47] = mk(0, R,   0,  0,  0, 0,  0,  0,  0,  NONE, 0);

    for (int i = 0; i < 48; i++) begin
      @(posedge clk);
      #1;
      rst             = tbl[i].rst;
      bus.id_opcode   = tbl[i].op;
      bus.id_rs1      = tbl[i].rs1;
      bus.id_rs2      = tbl[i].rs2;
      bus.ex_load     = tbl[i].ld;
      bus.ex_rd       = tbl[i].rd;
      bus.ex_redirect = tbl[i].redir;
      bus.mem_req     = tbl[i].req;
      bus.mem_ready   = tbl[i].rdy;
      e.idx = i; e.ctl = tbl[i].ctl; e.err = tbl[i].err; e.cnt = mcnt; e.cnt_chk = known;
      sbq.push_back(e);
      // counter model: value visible next cycle
      if (tbl[i].rst) begin
        mcnt  = '0;
        known = 1'b1;
      end else if (tbl[i].ctl[5] && (mcnt != {CNT_W{1'b1}})) begin
        mcnt = mcnt + 1'b1;
      end
    end

    @(posedge clk);
    #1;
    bus.mem_req = 1'b0;
    bus.ex_load = 1'b0;
    bus.ex_redirect = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (bus.stall_cycles !== mcnt) begin
      n_bad++;
      $display("FAIL final_stall_cycles: got %0d expected %0d", bus.stall_cycles, mcnt);
    end
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
